// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } t_arb_owner;

  localparam int ARB_STARVE_MAX = 4;

endpackage

// File: rtl/arb_prio.sv
// Combinational priority select between fetch and data requesters.
module arb_prio (
  input  logic if_req,
  input  logic d_req,
  input  logic if_flush,
  input  logic starve_hit,
  output logic if_gnt,
  output logic d_gnt
);

  // A flush blocks fetch outright; a starved fetch beats data, otherwise data wins.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (if_flush) begin
      d_gnt = d_req;
    end else if (starve_hit && if_req) begin
      if_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end else if (if_req) begin
      if_gnt = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory between fetch and load/store, routing
// the 1-cycle read data back to whichever requester owns it.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_adrs,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_byt_en,
  input  logic [ADDR_W-1:0]   d_adrs,
  input  logic [DATA_W-1:0]   d_wr_data,
  output logic                d_gnt,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic [ADDR_W-1:0]   mem_adrs_rd,
  output logic [ADDR_W-1:0]   mem_adrs_wr,
  output logic                mem_wr_en,
  output logic [DATA_W/8-1:0] mem_byt_en,
  output logic [DATA_W-1:0]   mem_wr_data,
  input  logic [DATA_W-1:0]   mem_rd_data
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  t_arb_owner        rsp_owner;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starve_hit;
  logic              store_gnt;
  logic              load_gnt;
  logic [ADDR_W-1:0] last_rd_adrs;
  logic [ADDR_W-1:0] last_wr_adrs;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));

  // Requests are masked while reset is held so no grant or strobe leaks out.
  arb_prio u_prio (
    .if_req     (if_req && rst),
    .d_req      (d_req && rst),
    .if_flush   (if_flush),
    .starve_hit (starve_hit),
    .if_gnt     (if_gnt),
    .d_gnt      (d_gnt)
  );

  assign store_gnt = d_gnt && d_we;
  assign load_gnt  = d_gnt && !d_we;

  // Addresses are live in the grant cycle and otherwise hold the last one issued.
  always_comb begin
    mem_adrs_rd = last_rd_adrs;
    if (if_gnt) begin
      mem_adrs_rd = if_adrs;
    end else if (load_gnt) begin
      mem_adrs_rd = d_adrs;
    end
    mem_adrs_wr = store_gnt ? d_adrs : last_wr_adrs;
    mem_wr_en   = store_gnt;
    mem_byt_en  = store_gnt ? d_byt_en : '0;
    mem_wr_data = store_gnt ? d_wr_data : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_owner    <= OWN_NONE;
      starve_cnt   <= '0;
      last_rd_adrs <= '0;
      last_wr_adrs <= '0;
    end else begin
      if (if_gnt) begin
        last_rd_adrs <= if_adrs;
      end else if (load_gnt) begin
        last_rd_adrs <= d_adrs;
      end
      if (store_gnt) begin
        last_wr_adrs <= d_adrs;
      end

      if (if_gnt) begin
        rsp_owner <= OWN_IF;
      end else if (load_gnt) begin
        rsp_owner <= OWN_D;
      end else begin
        rsp_owner <= OWN_NONE;
      end

      if (if_flush || !if_req || if_gnt) begin
        starve_cnt <= '0;
      end else if (!starve_hit) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // A flush landing on the fetch response cycle drops that instruction for good.
  assign if_rsp_valid = (rsp_owner == OWN_IF) && !if_flush;
  assign d_rsp_valid  = (rsp_owner == OWN_D);
  assign if_rsp_data  = if_rsp_valid ? mem_rd_data : '0;
  assign d_rsp_data   = d_rsp_valid ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected
// responses, a monitor pops and compares whenever a response is valid.
module tb_mem_arbiter;

  localparam int KIND_NONE = 0;
  localparam int KIND_IF   = 1;
  localparam int KIND_D    = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } t_exp;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_adrs;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_byt_en;
  logic [31:0] d_adrs;
  logic [31:0] d_wr_data;
  logic        d_gnt;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic [31:0] mem_adrs_rd;
  logic [31:0] mem_adrs_wr;
  logic        mem_wr_en;
  logic [3:0]  mem_byt_en;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  int   checks   = 0;
  int   failures = 0;
  t_exp exp_q[$];

  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] merged;

  mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_adrs      (if_adrs),
    .if_flush     (if_flush),
    .if_gnt       (if_gnt),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_byt_en     (d_byt_en),
    .d_adrs       (d_adrs),
    .d_wr_data    (d_wr_data),
    .d_gnt        (d_gnt),
    .d_rsp_valid  (d_rsp_valid),
    .d_rsp_data   (d_rsp_data),
    .mem_adrs_rd  (mem_adrs_rd),
    .mem_adrs_wr  (mem_adrs_wr),
    .mem_wr_en    (mem_wr_en),
    .mem_byt_en   (mem_byt_en),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  // Synchronous-read memory with byte-enabled writes.
  always @(posedge clk) begin
    if (mem_wr_en) begin
      merged = memRead(mem_adrs_wr);
      for (int b = 0; b < 4; b++) begin
        if (mem_byt_en[b]) merged[b*8 +: 8] = mem_wr_data[b*8 +: 8];
      end
      mem_model[mem_adrs_wr] = merged;
    end
    mem_rd_data <= memRead(mem_adrs_rd);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Drives one cycle of requests, checks the grants, and queues the expected response.
  task automatic applyStimulus(
    input logic ir, input logic [31:0] ia, input logic fl,
    input logic dr, input logic dw, input logic [3:0] be,
    input logic [31:0] da, input logic [31:0] wd,
    input logic exp_ig, input logic exp_dg,
    input int kind, input logic [31:0] rdata);
    t_exp e;
    @(posedge clk);
    #1;
    if_req    = ir;
    if_adrs   = ia;
    if_flush  = fl;
    d_req     = dr;
    d_we      = dw;
    d_byt_en  = be;
    d_adrs    = da;
    d_wr_data = wd;
    @(negedge clk);
    checkOutput("if_gnt", {31'b0, if_gnt}, {31'b0, exp_ig});
    checkOutput("d_gnt", {31'b0, d_gnt}, {31'b0, exp_dg});
    if (kind != KIND_NONE) begin
      e.kind = kind;
      e.data = rdata;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, KIND_NONE, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_if_gnt"}, {31'b0, if_gnt}, 0);
    checkOutput({tag, "_d_gnt"}, {31'b0, d_gnt}, 0);
    checkOutput({tag, "_if_rsp_valid"}, {31'b0, if_rsp_valid}, 0);
    checkOutput({tag, "_d_rsp_valid"}, {31'b0, d_rsp_valid}, 0);
    checkOutput({tag, "_if_rsp_data"}, if_rsp_data, 0);
    checkOutput({tag, "_d_rsp_data"}, d_rsp_data, 0);
    checkOutput({tag, "_mem_wr_en"}, {31'b0, mem_wr_en}, 0);
    checkOutput({tag, "_mem_byt_en"}, {28'b0, mem_byt_en}, 0);
    checkOutput({tag, "_mem_adrs_rd"}, mem_adrs_rd, 0);
    checkOutput({tag, "_mem_adrs_wr"}, mem_adrs_wr, 0);
    checkOutput({tag, "_mem_wr_data"}, mem_wr_data, 0);
  endtask

  // Response monitor: every valid response must match the head of the scoreboard.
  initial begin
    t_exp e;
    forever begin
      @(negedge clk);
      if (if_rsp_valid || d_rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_rsp if_valid=%0b d_valid=%0b required none",
                   if_rsp_valid, d_rsp_valid);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp_if_valid", {31'b0, if_rsp_valid}, 32'(e.kind == KIND_IF));
          checkOutput("rsp_d_valid", {31'b0, d_rsp_valid}, 32'(e.kind == KIND_D));
          checkOutput("rsp_data", if_rsp_valid ? if_rsp_data : d_rsp_data, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not complete required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mem_model[32'h100] = 32'h00500093;
    mem_model[32'h104] = 32'h00A00113;
    mem_model[32'h200] = 32'hDEADBEEF;
    mem_model[32'h300] = 32'hFFFFFFFF;
    mem_model[32'h400] = 32'h11111111;

    // Reset with every request asserted: all outputs must stay at zero.
    rst       = 1'b0;
    if_req    = 1'b1;
    if_adrs   = 32'h100;
    if_flush  = 1'b0;
    d_req     = 1'b1;
    d_we      = 1'b1;
    d_byt_en  = 4'hF;
    d_adrs    = 32'h300;
    d_wr_data = 32'hA5A5A5A5;
    #3;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
    rst    = 1'b1;
    $display("[TB] reset released");

    // Fetch only.
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, KIND_IF, 32'h00500093);
    checkOutput("fetch_rd_adrs", mem_adrs_rd, 32'h100);
    checkOutput("fetch_wr_en", {31'b0, mem_wr_en}, 0);
    idle(1);

    // Load and fetch together: data first, fetch the next cycle.
    applyStimulus(1, 32'h104, 0, 1, 0, 0, 32'h200, 0, 0, 1, KIND_D, 32'hDEADBEEF);
    checkOutput("load_rd_adrs", mem_adrs_rd, 32'h200);
    applyStimulus(1, 32'h104, 0, 0, 0, 0, 0, 0, 1, 0, KIND_IF, 32'h00A00113);
    idle(1);
    checkOutput("idle_rd_adrs_hold", mem_adrs_rd, 32'h104);

    // Partial store, then a zero-byte-enable store, then read back.
    applyStimulus(0, 0, 0, 1, 1, 4'b0011, 32'h300, 32'h12345678, 0, 1, KIND_NONE, 0);
    checkOutput("store_wr_en", {31'b0, mem_wr_en}, 1);
    checkOutput("store_byt_en", {28'b0, mem_byt_en}, 32'h3);
    checkOutput("store_adrs_wr", mem_adrs_wr, 32'h300);
    checkOutput("store_wr_data", mem_wr_data, 32'h12345678);
    idle(1);
    checkOutput("post_store_wr_en", {31'b0, mem_wr_en}, 0);
    checkOutput("post_store_byt_en", {28'b0, mem_byt_en}, 0);
    checkOutput("post_store_adrs_wr_hold", mem_adrs_wr, 32'h300);
    applyStimulus(0, 0, 0, 1, 1, 4'b0000, 32'h300, 32'h00000000, 0, 1, KIND_NONE, 0);
    checkOutput("zero_be_wr_en", {31'b0, mem_wr_en}, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 32'h300, 0, 0, 1, KIND_D, 32'hFFFF5678);
    idle(1);

    // Starvation: data wins four times, then the waiting fetch wins once.
    for (int c = 0; c < 6; c++) begin
      if (c == 4) begin
        applyStimulus(1, 32'h400, 0, 1, 0, 0, 32'h200, 0, 1, 0, KIND_IF, 32'h11111111);
      end else begin
        applyStimulus(1, 32'h400, 0, 1, 0, 0, 32'h200, 0, 0, 1, KIND_D, 32'hDEADBEEF);
      end
      checkOutput($sformatf("starve_cnt_c%0d", c), 32'(dut.starve_cnt), (c == 5) ? 0 : c);
    end
    idle(1);

    // Fetch granted, then flushed in the response cycle with the request still up.
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, KIND_NONE, 0);
    applyStimulus(1, 32'h104, 1, 0, 0, 0, 0, 0, 0, 0, KIND_NONE, 0);
    checkOutput("flush_if_rsp_valid", {31'b0, if_rsp_valid}, 0);
    checkOutput("flush_if_rsp_data", if_rsp_data, 0);
    idle(1);
    checkOutput("flush_cnt_cleared", 32'(dut.starve_cnt), 0);

    // Flush with a partly built starvation count: data still granted, count cleared.
    applyStimulus(1, 32'h400, 0, 1, 0, 0, 32'h200, 0, 0, 1, KIND_D, 32'hDEADBEEF);
    applyStimulus(1, 32'h400, 0, 1, 0, 0, 32'h200, 0, 0, 1, KIND_D, 32'hDEADBEEF);
    applyStimulus(1, 32'h400, 1, 1, 0, 0, 32'h200, 0, 0, 1, KIND_D, 32'hDEADBEEF);
    checkOutput("pre_flush_cnt", 32'(dut.starve_cnt), 2);
    applyStimulus(1, 32'h400, 0, 1, 0, 0, 32'h200, 0, 0, 1, KIND_D, 32'hDEADBEEF);
    checkOutput("post_flush_cnt", 32'(dut.starve_cnt), 0);
    idle(1);

    // Reset in the cycle after a load grant discards the response.
    applyStimulus(0, 0, 0, 1, 0, 0, 32'h200, 0, 0, 1, KIND_NONE, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    @(negedge clk);
    d_req = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_d_rsp_valid", {31'b0, d_rsp_valid}, 0);
    checkOutput("post_reset_if_rsp_valid", {31'b0, if_rsp_valid}, 0);

    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0, KIND_IF, 32'h00500093);
    idle(2);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one synchronous-read, single-port memory between the instruction-fetch requester and the load/store requester.
- Grants at most one access per cycle and routes the 1-cycle-latency read data back to the requester that owns it.
- Guarantees fetch forward progress with a starvation counter.
- Supports a fetch flush for redirected PCs.
- Sits between the pc/decoder front end and the unified memory instance.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_MAX, 4, consecutive cycles a pending fetch may lose before it wins priority.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- if_req  in  1  fetch request.
- if_adrs  in  ADDR_W  fetch address.
- if_flush  in  1  cancel fetch activity this cycle.
- if_gnt  out  1  fetch accepted this cycle.
- if_rsp_valid  out  1  fetch data valid.
- if_rsp_data  out  DATA_W  fetched instruction.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_byt_en  in  DATA_W/8  store byte enables.
- d_adrs  in  ADDR_W  data address.
- d_wr_data  in  DATA_W  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_rsp_valid  out  1  load data valid.
- d_rsp_data  out  DATA_W  load data.
- mem_adrs_rd  out  ADDR_W  memory read address.
- mem_adrs_wr  out  ADDR_W  memory write address.
- mem_wr_en  out  1  memory write strobe.
- mem_byt_en  out  DATA_W/8  memory byte enables.
- mem_wr_data  out  DATA_W  memory write data.
- mem_rd_data  in  DATA_W  memory read data, valid the cycle after the address.

Behaviour:
- Handshake:
  - A requester holds req and payload stable until it sees gnt.
  - gnt is combinational from the current req and state.
  - gnt is high for the acceptance cycle only.
  - A new grant may issue every cycle, back-to-back.
- Priority (per cycle):
  - (1) if_flush=1: no fetch grant; d_req is granted if present.
  - (2) starve_cnt==STARVE_MAX and if_req: fetch wins.
  - (3) d_req: data wins.
  - (4) if_req: fetch wins.
  - Exactly one gnt or none.
- Memory drive:
  - Granted read: mem_adrs_rd = granted address, mem_wr_en=0.
  - Granted store: mem_adrs_wr=d_adrs, mem_wr_en=1, mem_byt_en=d_byt_en, mem_wr_data=d_wr_data.
  - No grant: mem_wr_en=0, mem_byt_en=0; addresses hold the last value.
  - Stores with d_byt_en=0 are still granted; memory is unchanged.
- Response owner FSM (register rsp_owner, states OWN_NONE, OWN_IF, OWN_D):
  - Next state = OWN_IF if the fetch was granted, OWN_D if a load was granted, else OWN_NONE. Stores produce OWN_NONE.
  - if_rsp_valid = (rsp_owner==OWN_IF) && !if_flush.
  - d_rsp_valid = (rsp_owner==OWN_D).
  - rsp_data = mem_rd_data when valid, else 0.
  - A flush in the response cycle drops that instruction permanently; no replay.
- Starvation counter starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments when if_req && !if_gnt && !if_flush.
  - Saturates at STARVE_MAX.
  - Clears to 0 on if_gnt, on !if_req, or on if_flush.
- Reset (rst=0, async):
  - rsp_owner=OWN_NONE, starve_cnt=0.
  - All outputs 0: gnt, rsp_valid, rsp_data, mem_wr_en, mem_byt_en, addresses, wr_data.
  - Reset in the middle of an access discards the in-flight response; the first cycle after deassertion never shows rsp_valid.
- Simultaneous events:
  - Both requests with starve_cnt<STARVE_MAX: data granted.
  - Flush plus fetch response plus new fetch request: response dropped, request not granted, counter cleared.

Decomposition:
- cpu_pkg additions:
  - enum t_arb_owner {OWN_NONE, OWN_IF, OWN_D}.
  - Constant ARB_STARVE_MAX=4.
- Sub-module arb_prio: combinational priority select.
  - Inputs: if_req, d_req, if_flush, starve_hit.
  - Outputs: if_gnt, d_gnt.
- Registers (rsp_owner, starve_cnt) and datapath muxing stay in mem_arbiter.

Test Plan:
- Fetch only, if_adrs=0x100 and mem[0x100]=0x00500093: if_gnt same cycle; next cycle if_rsp_valid=1, if_rsp_data=0x00500093, d_rsp_valid=0.
- Load and fetch same cycle, d_adrs=0x200 with mem=0xDEADBEEF: d_gnt=1, if_gnt=0; next cycle d_rsp_data=0xDEADBEEF; fetch granted that same next cycle.
- Store d_adrs=0x300, d_byt_en=4'b0011, d_wr_data=0x12345678 over mem=0xFFFFFFFF: mem_wr_en=1 for one cycle, no d_rsp_valid; later load returns 0xFFFF5678.
- d_req held high for 6 cycles with if_req continuously high, STARVE_MAX=4: d_gnt in cycles 0-3, if_gnt in cycle 4, d_gnt in cycle 5; starve_cnt returns to 0.
- Fetch granted cycle N, if_flush=1 in N+1: if_rsp_valid=0 in N+1, no if_gnt in N+1, starve_cnt=0.
- rst=0 asserted in the cycle after a load grant: d_rsp_valid=0 immediately and in the first post-reset cycle; all outputs 0 during reset.
